ex_operand_latch: RTL and testbench

ID/EX pipeline register for the 16-bit execute stage. It captures decoded instruction fields and register-file operands at each clock edge and applies EX/MEM and MEM/WB forwarding. It presents ready operands to the ALU and to the shifter (`Shift_In`, `Shift_Val`, `Mode`). It handles stall (hold) and flush (bubble), and refreshes held operands while stalled so that forwarded values are not lost.

---
 rtl/ex_operand_latch.sv | 156 +++++++++++++++
 tb/tb_ex_operand_latch.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_latch.sv
// ID/EX pipeline register for the 16-bit execute stage.
// Captures decoded fields, forwards EX/MEM and MEM/WB results, and handles stall/flush.
module ex_operand_latch #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int OPC_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [OPC_W-1:0]  id_opcode,
    input  logic [REG_W-1:0]  id_rs_addr,
    input  logic [REG_W-1:0]  id_rt_addr,
    input  logic [REG_W-1:0]  id_rd_addr,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [3:0]        id_imm,
    input  logic              id_wr_en,
    input  logic              exm_wr_en,
    input  logic [REG_W-1:0]  exm_rd_addr,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_wr_en,
    input  logic [REG_W-1:0]  mwb_rd_addr,
    input  logic [DATA_W-1:0] mwb_result,
    output logic              ex_valid,
    output logic [OPC_W-1:0]  ex_opcode,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic [REG_W-1:0]  ex_rd_addr,
    output logic              ex_wr_en,
    output logic [DATA_W-1:0] shift_in,
    output logic [3:0]        shift_val,
    output logic              shift_mode,
    output logic              ex_is_shift,
    output logic              ex_is_ror
);

    localparam logic [OPC_W-1:0] OPC_SLL = OPC_W'(4);
    localparam logic [OPC_W-1:0] OPC_SRA = OPC_W'(5);
    localparam logic [OPC_W-1:0] OPC_ROR = OPC_W'(6);

    logic              valid_q,   valid_d;
    logic [OPC_W-1:0]  opcode_q,  opcode_d;
    logic [REG_W-1:0]  rs_addr_q, rs_addr_d;
    logic [REG_W-1:0]  rt_addr_q, rt_addr_d;
    logic [REG_W-1:0]  rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [3:0]        imm_q,     imm_d;
    logic              wr_en_q,   wr_en_d;

    logic [DATA_W-1:0] op_a, op_b;

    // EX/MEM is the younger producer so it is tested first; r0 is hardwired and never forwarded.
    function automatic logic [DATA_W-1:0] fwd_operand(
        input logic [REG_W-1:0]  addr,
        input logic [DATA_W-1:0] reg_data,
        input logic              e_we,
        input logic [REG_W-1:0]  e_rd,
        input logic [DATA_W-1:0] e_res,
        input logic              m_we,
        input logic [REG_W-1:0]  m_rd,
        input logic [DATA_W-1:0] m_res
    );
        logic [DATA_W-1:0] r;
        r = reg_data;
        if (addr != '0) begin
            if (e_we && (e_rd == addr))      r = e_res;
            else if (m_we && (m_rd == addr)) r = m_res;
        end
        return r;
    endfunction

    always_comb begin
        op_a = fwd_operand(rs_addr_q, rs_data_q, exm_wr_en, exm_rd_addr, exm_result,
                           mwb_wr_en, mwb_rd_addr, mwb_result);
        op_b = fwd_operand(rt_addr_q, rt_data_q, exm_wr_en, exm_rd_addr, exm_result,
                           mwb_wr_en, mwb_rd_addr, mwb_result);
    end

    always_comb begin
        valid_d   = valid_q;
        opcode_d  = opcode_q;
        rs_addr_d = rs_addr_q;
        rt_addr_d = rt_addr_q;
        rd_addr_d = rd_addr_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        wr_en_d   = wr_en_q;
        if (flush) begin
            valid_d   = 1'b0;
            opcode_d  = '0;
            rs_addr_d = '0;
            rt_addr_d = '0;
            rd_addr_d = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            wr_en_d   = 1'b0;
        end else if (stall) begin
            // Re-capture forwarded operands so a producer retiring mid-stall is not lost.
            rs_data_d = op_a;
            rt_data_d = op_b;
        end else begin
            valid_d   = id_valid;
            opcode_d  = id_opcode;
            rs_addr_d = id_rs_addr;
            rt_addr_d = id_rt_addr;
            rd_addr_d = id_rd_addr;
            rs_data_d = id_rs_data;
            rt_data_d = id_rt_data;
            imm_d     = id_imm;
            wr_en_d   = id_wr_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            rd_addr_q <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            wr_en_q   <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            rs_addr_q <= rs_addr_d;
            rt_addr_q <= rt_addr_d;
            rd_addr_q <= rd_addr_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            wr_en_q   <= wr_en_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_opcode   = opcode_q;
    assign ex_op_a     = op_a;
    assign ex_op_b     = op_b;
    assign ex_rd_addr  = rd_addr_q;
    assign ex_wr_en    = valid_q & wr_en_q;
    assign shift_in    = op_a;
    assign shift_val   = imm_q;
    assign shift_mode  = opcode_q[0];
    assign ex_is_shift = valid_q & ((opcode_q == OPC_SLL) | (opcode_q == OPC_SRA));
    assign ex_is_ror   = valid_q & (opcode_q == OPC_ROR);

endmodule

// File: tb/tb_ex_operand_latch.sv
// Randomized bench for ex_operand_latch: a slot-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ex_operand_latch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, id_valid = 1'b0, id_wr_en = 1'b0;
    logic [3:0]  id_opcode = '0, id_rs_addr = '0, id_rt_addr = '0, id_rd_addr = '0, id_imm = '0;
    logic [15:0] id_rs_data = '0, id_rt_data = '0;
    logic        exm_wr_en = 1'b0, mwb_wr_en = 1'b0;
    logic [3:0]  exm_rd_addr = '0, mwb_rd_addr = '0;
    logic [15:0] exm_result = '0, mwb_result = '0;

    logic        ex_valid, ex_wr_en, shift_mode, ex_is_shift, ex_is_ror;
    logic [3:0]  ex_opcode, ex_rd_addr, shift_val;
    logic [15:0] ex_op_a, ex_op_b, shift_in;

    int checks = 0;
    int errors = 0;

    ex_operand_latch #(.DATA_W(16), .REG_W(4), .OPC_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_wr_en(id_wr_en),
        .exm_wr_en(exm_wr_en), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
        .mwb_wr_en(mwb_wr_en), .mwb_rd_addr(mwb_rd_addr), .mwb_result(mwb_result),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_rd_addr(ex_rd_addr), .ex_wr_en(ex_wr_en), .shift_in(shift_in),
        .shift_val(shift_val), .shift_mode(shift_mode), .ex_is_shift(ex_is_shift),
        .ex_is_ror(ex_is_ror)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [3:0]  opc;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [3:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  imm;
        logic        we;
    } slot_t;

    slot_t m = '0;

    // Operand value an instruction should see given the producers in flight right now.
    function automatic logic [15:0] seen(input logic [3:0] r, input logic [15:0] d);
        if (r == 4'd0) return d;
        if (exm_wr_en && exm_rd_addr == r) return exm_result;
        if (mwb_wr_en && mwb_rd_addr == r) return mwb_result;
        return d;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m = '0;
        end else if (flush) begin
            m = '0;
        end else if (stall) begin
            slot_t h;
            h = m;
            h.a = seen(m.rs, m.a);
            h.b = seen(m.rt, m.b);
            m = h;
        end else begin
            m = '{id_valid, id_opcode, id_rs_addr, id_rt_addr, id_rd_addr,
                  id_rs_data, id_rt_data, id_imm, id_wr_en};
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("m_valid",  {15'd0, ex_valid}, {15'd0, m.v});
        chk("m_opcode", {12'd0, ex_opcode}, {12'd0, m.opc});
        chk("m_op_a",   ex_op_a, seen(m.rs, m.a));
        chk("m_op_b",   ex_op_b, seen(m.rt, m.b));
        chk("m_rd",     {12'd0, ex_rd_addr}, {12'd0, m.rd});
        chk("m_wr_en",  {15'd0, ex_wr_en}, {15'd0, m.v & m.we});
        chk("m_shin",   shift_in, seen(m.rs, m.a));
        chk("m_shval",  {12'd0, shift_val}, {12'd0, m.imm});
        chk("m_mode",   {15'd0, shift_mode}, {15'd0, m.opc[0]});
        chk("m_shift",  {15'd0, ex_is_shift}, {15'd0, m.v & (m.opc == 4'd4 || m.opc == 4'd5)});
        chk("m_ror",    {15'd0, ex_is_ror}, {15'd0, m.v & (m.opc == 4'd6)});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic v, input logic [3:0] opc, input logic [3:0] rs,
                        input logic [3:0] rt, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] imm, input logic we);
        id_valid = v; id_opcode = opc; id_rs_addr = rs; id_rt_addr = rt;
        id_rd_addr = 4'd7; id_rs_data = a; id_rt_data = b; id_imm = imm; id_wr_en = we;
        stall = 1'b0; flush = 1'b0;
        exm_wr_en = 1'b0; mwb_wr_en = 1'b0;
        step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {15'd0, ex_valid}, 16'd0);
        chk({tag, "_opc"},   {12'd0, ex_opcode}, 16'd0);
        chk({tag, "_op_a"},  ex_op_a, 16'd0);
        chk({tag, "_op_b"},  ex_op_b, 16'd0);
        chk({tag, "_rd"},    {12'd0, ex_rd_addr}, 16'd0);
        chk({tag, "_wr"},    {15'd0, ex_wr_en}, 16'd0);
        chk({tag, "_shin"},  shift_in, 16'd0);
        chk({tag, "_shval"}, {12'd0, shift_val}, 16'd0);
        chk({tag, "_shift"}, {15'd0, ex_is_shift}, 16'd0);
        chk({tag, "_ror"},   {15'd0, ex_is_ror}, 16'd0);
    endtask

    initial begin
        // Reset
        id_valid = 1'b1; id_opcode = 4'd6; id_rs_data = 16'h5555; id_imm = 4'd9;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Plain load of an SRA
        load(1'b1, 4'b0101, 4'd1, 4'd2, 16'h8000, 16'h0001, 4'd4, 1'b1);
        chk("load_shin",  shift_in, 16'h8000);
        chk("load_shval", {12'd0, shift_val}, 16'd4);
        chk("load_mode",  {15'd0, shift_mode}, 16'd1);
        chk("load_shift", {15'd0, ex_is_shift}, 16'd1);
        chk("load_wr",    {15'd0, ex_wr_en}, 16'd1);

        // Both producers match rs=3: EX/MEM wins
        load(1'b1, 4'd1, 4'd3, 4'd4, 16'h0bad, 16'h0042, 4'd0, 1'b1);
        exm_wr_en = 1'b1; exm_rd_addr = 4'd3; exm_result = 16'h1111;
        mwb_wr_en = 1'b1; mwb_rd_addr = 4'd3; mwb_result = 16'h2222;
        #1 chk("dual_exm", ex_op_a, 16'h1111);
        chk("dual_b_untouched", ex_op_b, 16'h0042);
        exm_wr_en = 1'b0;
        #1 chk("dual_mwb", ex_op_a, 16'h2222);
        mwb_wr_en = 1'b0;
        #1 chk("dual_none", ex_op_a, 16'h0bad);

        // Register 0 is never forwarded
        load(1'b1, 4'd2, 4'd0, 4'd0, 16'h0000, 16'h0000, 4'd0, 1'b0);
        exm_wr_en = 1'b1; exm_rd_addr = 4'd0; exm_result = 16'hFFFF;
        #1 chk("r0_a", ex_op_a, 16'h0000);
        chk("r0_b", ex_op_b, 16'h0000);
        exm_wr_en = 1'b0;

        // Stall refresh: MEM/WB forwards once, then retires while stalled
        load(1'b1, 4'd3, 4'd1, 4'd5, 16'h0011, 16'h1234, 4'd0, 1'b1);
        stall = 1'b1;
        mwb_wr_en = 1'b1; mwb_rd_addr = 4'd5; mwb_result = 16'hABCD;
        id_rt_data = 16'h7777; id_rt_addr = 4'd9;
        #1 chk("stall_fwd", ex_op_b, 16'hABCD);
        step();
        mwb_wr_en = 1'b0; mwb_result = 16'h0000;
        #1 chk("stall_1", ex_op_b, 16'hABCD);
        step();
        chk("stall_2", ex_op_b, 16'hABCD);
        step();
        chk("stall_3", ex_op_b, 16'hABCD);
        chk("stall_hold_valid", {15'd0, ex_valid}, 16'd1);
        stall = 1'b0;
        step();
        chk("release_load", ex_op_b, 16'h7777);

        // Flush beats stall
        load(1'b1, 4'd4, 4'd1, 4'd2, 16'h0001, 16'h0002, 4'd3, 1'b1);
        chk("pre_flush_valid", {15'd0, ex_valid}, 16'd1);
        chk("pre_flush_wr",    {15'd0, ex_wr_en}, 16'd1);
        stall = 1'b1; flush = 1'b1;
        step();
        chk("flush_valid", {15'd0, ex_valid}, 16'd0);
        chk("flush_wr",    {15'd0, ex_wr_en}, 16'd0);
        chk("flush_shift", {15'd0, ex_is_shift}, 16'd0);
        chk("flush_op_a",  ex_op_a, 16'd0);

        // Asynchronous reset between edges
        load(1'b1, 4'd6, 4'd2, 4'd3, 16'h1357, 16'h2468, 4'd15, 1'b1);
        chk("pre_rst_ror", {15'd0, ex_is_ror}, 16'd1);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("arst");
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();

        // Randomized traffic with a small register window so matches are frequent
        for (int i = 0; i < 400; i++) begin
            id_valid    = 1'($urandom_range(0, 1));
            id_opcode   = 4'($urandom_range(0, 7));
            id_rs_addr  = 4'($urandom_range(0, 3));
            id_rt_addr  = 4'($urandom_range(0, 3));
            id_rd_addr  = 4'($urandom());
            id_rs_data  = 16'($urandom());
            id_rt_data  = 16'($urandom());
            id_imm      = 4'($urandom());
            id_wr_en    = 1'($urandom_range(0, 1));
            stall       = ($urandom_range(0, 9) < 4);
            flush       = ($urandom_range(0, 9) < 1);
            exm_wr_en   = 1'($urandom_range(0, 1));
            exm_rd_addr = 4'($urandom_range(0, 3));
            exm_result  = 16'($urandom());
            mwb_wr_en   = 1'($urandom_range(0, 1));
            mwb_rd_addr = 4'($urandom_range(0, 3));
            mwb_result  = 16'($urandom());
            step();
        end

        stall = 1'b0; flush = 1'b0;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
